// File: rtl/fp_dot_accum.sv
// fp_dot_accum
//   Fixed-point dot-product accumulator placed directly after fp_mult. It
//   sums each group of N_TERMS signed products plus a signed bias in a
//   widened accumulator. The sum is then saturated back to fp_width bits.
//   A typical use is one colour-space row, e.g. Cb = a*R + b*G + c*B + bias.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst_n      synchronous active-low reset
//   flush      synchronous abort of the partial group and any pending result
//   bias       signed bias, sampled only with the first term of a group
//   in_valid   product valid
//   in_ready   block can accept a product (combinational from out_ready)
//   in_data    signed product, fp_width bits
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   saturated signed sum
//   out_sat    saturation occurred for this result
//
// State table
//   state    | meaning
//   ST_ACCUM | collecting terms of the current group, no result pending
//   ST_OUT   | result presented on out_*, waiting for out_ready

module fp_dot_accum #(
  parameter int fp_width = 16,
  parameter int fp_frac  = 8,
  parameter int N_TERMS  = 3,
  parameter int GUARD    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [fp_width-1:0] bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [fp_width-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [fp_width-1:0] out_data,
  output logic                out_sat
);

  localparam int AW = fp_width + GUARD;
  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

  // Largest / smallest value representable in fp_width bits, in acc width.
  localparam logic signed [AW-1:0] MAX_V = {{(GUARD + 1){1'b0}}, {(fp_width - 1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(GUARD + 1){1'b1}}, {(fp_width - 1){1'b0}}};

  // The guard bits must hold N_TERMS products plus the bias without wrap.
  // The fraction position never enters the arithmetic, so it is only checked.
  if ((2 ** GUARD) < (N_TERMS + 1) || N_TERMS < 1 || fp_frac < 0 || fp_frac >= fp_width)
  begin : g_param_err
    $error("fp_dot_accum: illegal parameter combination");
  end

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [fp_width-1:0]   out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;

  logic                  in_hs;
  logic                  out_hs;
  logic signed [AW-1:0]  data_ext;
  logic signed [AW-1:0]  bias_ext;

  function automatic logic [fp_width:0] saturate(input logic signed [AW-1:0] a);
    logic [fp_width:0] r;
    if (a > MAX_V) begin
      r = {1'b1, 1'b0, {(fp_width - 1){1'b1}}};
    end else if (a < MIN_V) begin
      r = {1'b1, 1'b1, {(fp_width - 1){1'b0}}};
    end else begin
      r = {1'b0, a[fp_width-1:0]};
    end
    return r;
  endfunction

  assign data_ext  = {{GUARD{in_data[fp_width-1]}}, in_data};
  assign bias_ext  = {{GUARD{bias[fp_width-1]}}, bias};

  assign out_valid = (state_q == ST_OUT);
  assign in_ready  = (state_q == ST_ACCUM) | ((state_q == ST_OUT) & out_ready);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    if (flush) begin
      state_d = ST_ACCUM;
      count_d = '0;
      acc_d   = '0;
    end else begin
      if (out_hs) begin
        state_d = ST_ACCUM;
      end
      if (in_hs) begin
        // In ST_OUT an input handshake implies out_ready, so count_q is 0
        // and this term opens the next group.
        if (count_q == '0) begin
          acc_d = bias_ext + data_ext;
        end else begin
          acc_d = acc_q + data_ext;
        end
        if (count_q == LAST_CNT) begin
          count_d                 = '0;
          state_d                 = ST_OUT;
          {out_sat_d, out_data_d} = saturate(acc_d);
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      count_q    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fp_dot_accum.sv
module tb_fp_dot_accum;

  localparam int W = 16;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [W-1:0] bias;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sat;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of accepted terms of the open group, the bias
  // captured with its first term, and at most one pending result.
  int           m_terms[$];
  int           m_bias;
  bit           m_has;
  logic [W-1:0] m_data;
  bit           m_sat;
  int           m_results;

  fp_dot_accum #(.fp_width(W), .fp_frac(8), .N_TERMS(N), .GUARD(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int s16(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_result(input int sum);
    m_has = 1'b1;
    m_results++;
    if (sum > 32767) begin
      m_data = 16'h7FFF; m_sat = 1'b1;
    end else if (sum < -32768) begin
      m_data = 16'h8000; m_sat = 1'b1;
    end else begin
      m_data = 16'(sum); m_sat = 1'b0;
    end
  endtask

  // One clock: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input bit iv, input logic [W-1:0] d, input logic [W-1:0] b,
                      input bit ordy, input bit fl);
    bit exp_ready;
    int sum;
    @(negedge clk);
    in_valid = iv; in_data = d; bias = b; out_ready = ordy; flush = fl;
    #1;
    exp_ready = !m_has || ordy;
    chk("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (fl) begin
      m_terms.delete();
      m_has = 1'b0;
    end else begin
      if (m_has && ordy) m_has = 1'b0;
      if (iv && exp_ready) begin
        if (m_terms.size() == 0) m_bias = s16(b);
        m_terms.push_back(s16(d));
        if (m_terms.size() == N) begin
          sum = m_bias;
          foreach (m_terms[i]) sum += m_terms[i];
          m_terms.delete();
          model_result(sum);
        end
      end
    end
    #1;
    chk("out_valid", out_valid, m_has);
    if (m_has) begin
      chk("out_data", out_data, m_data);
      chk("out_sat", out_sat, m_sat);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    m_terms.delete();
    m_has = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_sat", out_sat, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int start_res;
    rst_n = 1'b0; flush = 1'b0; bias = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_has = 1'b0; m_bias = 0; m_data = '0; m_sat = 1'b0; m_results = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic sum
    step(1, 16'h0100, 16'h0010, 1, 0);
    step(1, 16'h0080, 16'h0000, 1, 0);
    step(1, 16'hFF80, 16'h0000, 0, 0);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_data", out_data, 16'h0110);
    chk("basic_sat", out_sat, 1'b0);
    step(0, 16'h0000, 16'h0000, 1, 0);

    // Positive and negative overflow
    for (int i = 0; i < N; i++) step(1, 16'h7000, 16'h0000, 0, 0);
    chk("pos_sat_data", out_data, 16'h7FFF);
    chk("pos_sat_flag", out_sat, 1'b1);
    step(0, 16'h0000, 16'h0000, 1, 0);
    for (int i = 0; i < N; i++) step(1, 16'h9000, 16'h0000, 0, 0);
    chk("neg_sat_data", out_data, 16'h8000);
    chk("neg_sat_flag", out_sat, 1'b1);
    step(0, 16'h0000, 16'h0000, 1, 0);

    // Backpressure, then simultaneous handshakes
    step(1, 16'h0100, 16'h0000, 1, 0);
    step(1, 16'h0100, 16'h0000, 1, 0);
    step(1, 16'h0100, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h1234, 16'h0000, 0, 0);
    chk("bp_data", out_data, 16'h0300);
    step(1, 16'h0200, 16'h0000, 1, 0);
    step(1, 16'h0100, 16'h0000, 1, 0);
    step(1, 16'h0100, 16'h0000, 0, 0);
    chk("bp_next_data", out_data, 16'h0400);
    step(0, 16'h0000, 16'h0000, 1, 0);

    // Streaming: 4 groups back to back
    start_res = m_results;
    for (int i = 0; i < 4 * N; i++) step(1, 16'(16 * (i + 1)), 16'h0008, 1, 0);
    chk("stream_count", m_results - start_res, 4);
    step(0, 16'h0000, 16'h0000, 1, 0);

    // Flush mid-group, with a discarded term in the flush cycle
    step(1, 16'h0100, 16'h0000, 1, 0);
    step(1, 16'h0100, 16'h0000, 1, 0);
    step(1, 16'h0100, 16'h0000, 1, 1);
    chk("flush_no_out", out_valid, 1'b0);
    step(1, 16'h0040, 16'h0000, 1, 0);
    step(1, 16'h0040, 16'h0000, 1, 0);
    step(1, 16'h0040, 16'h0000, 0, 0);
    chk("flush_data", out_data, 16'h00C0);
    step(0, 16'h0000, 16'h0000, 1, 0);

    // Reset while a result is pending
    for (int i = 0; i < N; i++) step(1, 16'h0111, 16'h0000, 0, 0);
    do_reset();
    step(1, 16'h0020, 16'h0001, 1, 0);
    step(1, 16'h0020, 16'h0000, 1, 0);
    step(1, 16'h0020, 16'h0000, 0, 0);
    chk("post_rst_data", out_data, 16'h0061);
    step(0, 16'h0000, 16'h0000, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] d, b;
      d = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
      b = 16'($urandom);
      step($urandom_range(3) != 0, d, b, $urandom_range(3) != 0, $urandom_range(40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
